// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display slice.
// FSM states, field limits, active-high segment patterns, BCD adjust helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam logic [6:0] CS_MAX  = 7'd99;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [6:0] MIN_MAX = 7'd99;

  // Active-high, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_ZERO = 7'b0111111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // Double-dabble correction: add 3 to each nibble >= 5
  function automatic logic [7:0] dd_adj(input logic [7:0] b);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
    hi = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
    return {hi, lo};
  endfunction

endpackage

// File: rtl/stopwatch_display_bcd_to_7seg.sv
// One BCD digit to active-high seven-segment pattern (combinational).
// Ports: bcd_i (4-bit digit), seg_o (7-bit, bit0=a ... bit6=g); 10-15 blank.
module bcd_to_7seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    unique case (bcd_i)
      4'd0:    seg_o = SEG_ZERO;
      4'd1:    seg_o = 7'b0000110;
      4'd2:    seg_o = 7'b1011011;
      4'd3:    seg_o = 7'b1001111;
      4'd4:    seg_o = 7'b1100110;
      4'd5:    seg_o = 7'b1101101;
      4'd6:    seg_o = 7'b1111101;
      4'd7:    seg_o = 7'b0000111;
      4'd8:    seg_o = 7'b1111111;
      4'd9:    seg_o = 7'b1101111;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch time to six 7-seg digits via a serial double-dabble FSM.
// Ports: clk, rst, tick, cs/sec/min, hold in; hex0..hex5, busy out (registered).
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [6:0] cs,
  input  logic [5:0] sec,
  input  logic [6:0] min,
  input  logic       hold,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic       busy
);

  localparam logic [6:0] HEX_RST =
    ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;

  // Inputs are registered first; this stage is
  // part of the 23-edge tick-to-display latency.
  logic       tick_q, hold_q;
  logic [6:0] cs_q, min_q;
  logic [5:0] sec_q;

  state_t     state_q, state_d;
  logic       pend_q, pend_d;
  logic       busy_q, busy_d;
  logic [6:0] snap_cs_q, snap_cs_d;
  logic [5:0] snap_sec_q, snap_sec_d;
  logic [6:0] snap_min_q, snap_min_d;
  logic [1:0] fld_q, fld_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] bin_q, bin_d;
  logic [7:0] bcd_q, bcd_d;
  logic [7:0] res_q [3];
  logic [7:0] res_d [3];
  logic [6:0] hex_q [6];
  logic [6:0] hex_d [6];

  logic [6:0] dec [6];
  logic [6:0] seg_nx [6];
  logic       oor [3];
  logic       accept;
  logic [7:0] bcd_nx;

  assign accept = tick_q & ~hold_q;
  assign bcd_nx = {dd_adj(bcd_q), bin_q[6]} >> 1 << 1 | 8'(bin_q[6]);

  assign oor[0] = snap_cs_q > CS_MAX;
  assign oor[1] = snap_sec_q > SEC_MAX;
  assign oor[2] = snap_min_q > MIN_MAX;

  for (genvar i = 0; i < 6; i++) begin : g_dig
    logic [3:0] digit;
    logic [6:0] raw;
    assign digit = i[0] ? res_q[i/2][7:4]
                        : res_q[i/2][3:0];
    bcd_to_7seg u_dec (
      .bcd_i (digit),
      .seg_o (dec[i])
    );
    assign raw = oor[i/2] ? SEG_DASH : dec[i];
    assign seg_nx[i] = ACTIVE_LOW ? ~raw : raw;
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    snap_cs_d  = snap_cs_q;
    snap_sec_d = snap_sec_q;
    snap_min_d = snap_min_q;
    fld_d      = fld_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    res_d      = res_q;
    hex_d      = hex_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          snap_cs_d  = cs_q;
          snap_sec_d = sec_q;
          snap_min_d = min_q;
          fld_d      = 2'd0;
          cnt_d      = 3'd0;
          bin_d      = cs_q;
          bcd_d      = 8'd0;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (accept) pend_d = 1'b1;
        bcd_d = bcd_nx;
        bin_d = {bin_q[5:0], 1'b0};
        if (cnt_q == 3'd6) begin
          res_d[fld_q] = bcd_nx;
          cnt_d = 3'd0;
          bcd_d = 8'd0;
          if (fld_q == 2'd2) begin
            state_d = UPDATE;
          end else begin
            fld_d = fld_q + 2'd1;
            bin_d = (fld_q == 2'd0)
              ? {1'b0, snap_sec_q} : snap_min_q;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      UPDATE: begin
        hex_d = seg_nx;
        // A tick seen now is treated like a pending one.
        if (pend_q || accept) begin
          pend_d     = 1'b0;
          snap_cs_d  = cs_q;
          snap_sec_d = sec_q;
          snap_min_d = min_q;
          fld_d      = 2'd0;
          cnt_d      = 3'd0;
          bin_d      = cs_q;
          bcd_d      = 8'd0;
          state_d    = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q     <= 1'b0;
      hold_q     <= 1'b0;
      cs_q       <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      snap_cs_q  <= '0;
      snap_sec_q <= '0;
      snap_min_q <= '0;
      fld_q      <= '0;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      for (int i = 0; i < 3; i++) res_q[i] <= '0;
      for (int i = 0; i < 6; i++) hex_q[i] <= HEX_RST;
    end else begin
      tick_q     <= tick;
      hold_q     <= hold;
      cs_q       <= cs;
      sec_q      <= sec;
      min_q      <= min;
      state_q    <= state_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      snap_cs_q  <= snap_cs_d;
      snap_sec_q <= snap_sec_d;
      snap_min_q <= snap_min_d;
      fld_q      <= fld_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      res_q      <= res_d;
      hex_q      <= hex_d;
    end
  end

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign busy = busy_q;

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 SHALL have parameter ACTIVE_LOW, default 1, meaning segment outputs are active-low (DE-board HEX style); 0 inverts all segment outputs.
REQ-002 SHALL have clk  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have tick  input  1  one-cycle strobe from the stopwatch counter stage, high on the cycle after cs/sec/min update.
REQ-005 SHALL have cs  input  7  centiseconds, binary, legal 0-99.
REQ-006 SHALL have sec  input  6  seconds, binary, legal 0-59.
REQ-007 SHALL have min  input  7  minutes, binary, legal 0-99.
REQ-008 SHALL have hold  input  1  lap freeze; while high, new ticks are not accepted.
REQ-009 SHALL have hex0..hex5  output  7 each  segment patterns, bit0=a ... bit6=g; hex0/hex1 = cs units/tens, hex2/hex3 = sec units/tens, hex4/hex5 = min units/tens.
REQ-010 SHALL have busy  output  1  high while a conversion is in progress.

Function
REQ-011 SHALL use FSM states IDLE, CONV, UPDATE.
REQ-012 In IDLE, tick=1 with hold=0 SHALL snapshot cs, sec, min into internal registers and move to CONV with field index 0 (cs) and shift count 0.
REQ-013 CONV SHALL perform one serial double-dabble iteration per cycle (add 3 to any BCD nibble >=5, then shift one binary bit in, MSB first), 7 iterations per field.
REQ-014 Field order SHALL be cs, sec, min; sec is zero-extended to 7 bits; after 7 iterations the two BCD digits SHALL be stored in a per-field result register and the next field started.
REQ-015 After 21 CONV cycles the FSM SHALL enter UPDATE for one cycle, during which all six hex outputs are registered together (no partially updated display), then return to IDLE.
REQ-016 Latency: hex outputs SHALL change on the 23rd rising edge after the edge that samples tick; busy SHALL be high for exactly 22 cycles (CONV plus UPDATE).
REQ-017 A tick accepted (hold=0) while busy=1 SHALL set a single pending flag; on leaving UPDATE with pending=1 the block SHALL clear pending, take a fresh snapshot, and re-enter CONV with no IDLE cycle; multiple ticks while busy collapse into one.
REQ-018 hold=1 SHALL suppress new snapshots and pending sets; a conversion already in progress SHALL complete and update the display.
REQ-019 A field whose snapshot value is out of range (cs>99, sec>59, min>99) SHALL display dash (segment g only) on both of its digits; other fields are unaffected.
REQ-020 Digit decode SHALL be the standard 0-9 seven-segment map (0 = a,b,c,d,e,f lit); no leading-zero blanking.
REQ-021 All outputs SHALL be registered; no combinational path from any input to hex0..hex5 or busy.

Reset
REQ-022 rst=1 SHALL asynchronously force state IDLE, busy=0, pending=0, snapshot and result registers to 0, and every hex output to the digit-0 pattern (7'b1000000 when ACTIVE_LOW=1).
REQ-023 rst asserted mid-conversion SHALL abort it; no update from the aborted conversion SHALL appear after rst deasserts.
REQ-024 The first tick accepted after rst deasserts SHALL follow REQ-016 latency exactly.

Structure
REQ-025 A shared package stopwatch_pkg SHALL hold the FSM state enum, field limits (CS_MAX=99, SEC_MAX=59, MIN_MAX=99), and segment constants SEG_ZERO, SEG_DASH, SEG_OFF (active-high form).
REQ-026 A sub-module bcd_to_7seg (4-bit BCD in, 7-bit active-high segments out, combinational) SHALL be instantiated six times; ACTIVE_LOW inversion and dash override SHALL be applied in stopwatch_display before the output registers.

Verification
REQ-027 Reset: assert rst mid-CONV -> all hex = 7'b1000000, busy=0 immediately; no later update without a new tick.
REQ-028 Basic: cs=47, sec=05, min=12, tick pulse -> after 23 edges hex5..hex0 show 1,2,0,5,4,7; busy high exactly 22 cycles.
REQ-029 Max legal: cs=99, sec=59, min=99 -> 9,9,5,9,9,9; then cs=0, sec=0, min=0 -> all zero pattern.
REQ-030 Out of range: cs=10, sec=60, min=120 -> hex3/hex2 and hex5/hex4 show SEG_DASH, hex1/hex0 show 1,0.
REQ-031 Pending: tick at cycle 0 (cs=1), tick at cycles 5 and 9 (cs=2, then cs=3) -> display 01 at edge 23, then 03 at edge 45 (snapshot taken leaving UPDATE), one restart only.
REQ-032 Hold: display 00:10:00, hold=1, ticks with cs=55 -> display unchanged, busy stays 0; hold=0 then tick -> new value after 23 edges.
